// File: rtl/pbit_unit.sv
// Single probabilistic bit: samples a Bernoulli output with P(1) = (1 + tanh(z))/2
// using a piecewise-linear tanh and an internal seedable 32-bit Galois LFSR.
module pbit_unit #(
  parameter int          N    = 7,
  parameter int          Q    = 2,
  parameter logic [31:0] INIT = 32'd1000000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [N-1:0] z,
  output logic         pbit_val
);

  localparam logic [31:0] SEED = (INIT == 32'd0) ? 32'h1 : INIT;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] ONE  = 32'd1 << Q;

  logic [31:0] lfsr_q, lfsr_d;
  logic        pbit_q, pbit_d;
  logic [31:0] c_ext;
  logic        s_neg;
  logic [7:0]  t;
  logic [9:0]  thr;
  logic [8:0]  r;

  // Magnitude widened to 32 bits so every segment product is overflow-free.
  always_comb begin
    c_ext = 32'(z[N-2:0]);
    s_neg = z[N-1] & (c_ext != 32'd0);
    if (c_ext < ONE) begin
      t = 8'((32'd192 * c_ext) >> Q);
    end else if (c_ext < 32'd2 * ONE) begin
      t = 8'(32'd192 + ((32'd48 * (c_ext - ONE)) >> Q));
    end else if (c_ext < 32'd3 * ONE) begin
      t = 8'(32'd240 + ((32'd12 * (c_ext - 32'd2 * ONE)) >> Q));
    end else begin
      t = 8'd255;
    end
    thr = s_neg ? (10'd256 - {2'b00, t}) : (10'd256 + {2'b00, t});
    r   = lfsr_q[8:0];
  end

  always_comb begin
    lfsr_d = lfsr_q;
    pbit_d = pbit_q;
    if (en) begin
      pbit_d = ({1'b0, r} < thr);
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= SEED;
      pbit_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      pbit_q <= pbit_d;
    end
  end

  assign pbit_val = pbit_q;

endmodule

// File: tb/tb_pbit_unit.sv
// Self-checking bench for pbit_unit: reference model of the tanh/threshold/LFSR
// rules, plus statistical and determinism scenarios across four instances.
module tb_pbit_unit;

  localparam int          N       = 7;
  localparam int          Q       = 2;
  localparam logic [31:0] SEED_A  = 32'h1;
  localparam logic [31:0] SEED_B  = 32'd1000000000;
  localparam logic [31:0] SEED_CD = 32'd2000000000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         a_rst = 1'b1, a_en = 1'b0;  logic [N-1:0] a_z = '0;  logic a_val;
  logic         b_rst = 1'b1, b_en = 1'b0;  logic [N-1:0] b_z = '0;  logic b_val;
  logic         c_rst = 1'b1, c_en = 1'b0;  logic [N-1:0] c_z = '0;  logic c_val;
  logic         d_rst = 1'b1, d_en = 1'b0;  logic [N-1:0] d_z = '0;  logic d_val;

  pbit_unit #(.N(N), .Q(Q), .INIT(32'd0)) dut_a (
    .CLK(CLK), .RST(a_rst), .en(a_en), .z(a_z), .pbit_val(a_val));
  pbit_unit #(.N(N), .Q(Q), .INIT(SEED_B)) dut_b (
    .CLK(CLK), .RST(b_rst), .en(b_en), .z(b_z), .pbit_val(b_val));
  pbit_unit #(.N(N), .Q(Q), .INIT(SEED_CD)) dut_c (
    .CLK(CLK), .RST(c_rst), .en(c_en), .z(c_z), .pbit_val(c_val));
  pbit_unit #(.N(N), .Q(Q), .INIT(SEED_CD)) dut_d (
    .CLK(CLK), .RST(d_rst), .en(d_en), .z(d_z), .pbit_val(d_val));

  int errors = 0;
  int checks = 0;
  logic [31:0] ma, mb, mc;

  // tanh(x) in 1/256 units, x = c / 2^Q, as a piecewise-linear table over unit intervals.
  function automatic int tanh_t(int c);
    int base [3];
    int slope [3];
    int seg;
    base  = '{0, 192, 240};
    slope = '{192, 48, 12};
    seg = c / (2 ** Q);
    if (seg >= 3) return 255;
    return base[seg] + (slope[seg] * (c - seg * (2 ** Q))) / (2 ** Q);
  endfunction

  function automatic logic model_bit(logic [31:0] lfsr, logic [N-1:0] zz);
    int c, t, thr;
    c = int'(zz[N-2:0]);
    t = tanh_t(c);
    thr = (zz[N-1] && c != 0) ? 256 - t : 256 + t;
    return int'(lfsr % 512) < thr;
  endfunction

  function automatic logic [31:0] lfsr_step(logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic exp;
    a_rst = 1'b1; a_en = 1'b1; a_z = 7'b0_0111_11;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (a_val !== 1'b0) begin
        errors++;
        $display("FAIL reset_val cycle %0d: got %b want 0", i, a_val);
      end
    end
    ma = SEED_A;
    a_rst = 1'b0; a_en = 1'b1; a_z = 7'b0_0000_00;
    exp = model_bit(ma, a_z);
    ma = lfsr_step(ma);
    tick;
    checks++;
    if (a_val !== exp) begin
      errors++;
      $display("FAIL first_sample: got %b want %b", a_val, exp);
    end
    checks++;
    if (dut_a.lfsr_q !== 32'h80200003) begin
      errors++;
      $display("FAIL first_lfsr: got %h want 80200003", dut_a.lfsr_q);
    end
    $display("reset/first sample: pbit_val=%b lfsr=%h", a_val, dut_a.lfsr_q);
  endtask

  task automatic test_hold;
    logic held, exp;
    held = a_val;
    a_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a_z = N'($urandom);
      tick;
      checks++;
      if (a_val !== held) begin
        errors++;
        $display("FAIL hold_val cycle %0d: got %b want %b", i, a_val, held);
      end
    end
    checks++;
    if (dut_a.lfsr_q !== ma) begin
      errors++;
      $display("FAIL hold_lfsr: got %h want %h", dut_a.lfsr_q, ma);
    end
    a_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      a_z = N'($urandom);
      exp = model_bit(ma, a_z);
      ma = lfsr_step(ma);
      tick;
      checks++;
      if (a_val !== exp) begin
        errors++;
        $display("FAIL resume_after_hold cycle %0d z=%b: got %b want %b", i, a_z, a_val, exp);
      end
    end
    $display("hold: 20 cycles held, 50 resumed samples checked");
  endtask

  task automatic test_stat(input string name, input logic [N-1:0] zval, input int lo, input int hi);
    int ones;
    logic exp;
    ones = 0;
    b_en = 1'b1; b_z = zval;
    for (int i = 0; i < 4096; i++) begin
      exp = model_bit(mb, zval);
      mb = lfsr_step(mb);
      tick;
      ones += int'(b_val);
      checks++;
      if (b_val !== exp) begin
        errors++;
        $display("FAIL %s sample %0d: got %b want %b", name, i, b_val, exp);
      end
    end
    checks++;
    if (ones < lo || ones > hi) begin
      errors++;
      $display("FAIL %s ones_count: got %0d want [%0d,%0d]", name, ones, lo, hi);
    end
    $display("stat %s z=%b: ones=%0d of 4096", name, zval, ones);
  endtask

  task automatic test_statistics;
    b_rst = 1'b1; b_en = 1'b0;
    tick;
    b_rst = 1'b0;
    mb = SEED_B;
    test_stat("sat_pos_7p75", 7'b0_0111_11, 4060, 4096);
    test_stat("sat_pos_3p0",  7'b0_0011_00, 4060, 4096);
    test_stat("sat_neg_8",    7'b1_1000_00, 0, 30);
    test_stat("zero",         7'b0_0000_00, 1900, 2200);
    test_stat("pos_1p0",      7'b0_0001_00, 3434, 3734);
    test_stat("neg_1p0",      7'b1_0001_00, 412, 612);
  endtask

  task automatic test_random;
    logic exp;
    int resets;
    resets = 0;
    for (int i = 0; i < 2000; i++) begin
      b_rst = ($urandom_range(0, 63) == 0);
      b_en  = ($urandom_range(0, 3) != 0);
      b_z   = N'($urandom);
      if (b_rst) begin
        exp = 1'b0;
        mb = SEED_B;
        resets++;
      end else if (b_en) begin
        exp = model_bit(mb, b_z);
        mb = lfsr_step(mb);
      end else begin
        exp = b_val;
      end
      tick;
      checks++;
      if (b_val !== exp) begin
        errors++;
        $display("FAIL random cycle %0d rst=%b en=%b z=%b: got %b want %b",
                 i, b_rst, b_en, b_z, b_val, exp);
      end
    end
    b_rst = 1'b0;
    $display("random: 2000 cycles, %0d resets", resets);
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] zs [100];
    logic         ens [100];
    logic         outs [100];
    logic         exp;
    for (int i = 0; i < 100; i++) begin
      zs[i]  = N'($urandom);
      ens[i] = ($urandom_range(0, 4) != 0);
    end
    c_rst = 1'b1; d_rst = 1'b1;
    tick;
    c_rst = 1'b0; d_rst = 1'b0;
    mc = SEED_CD;
    for (int i = 0; i < 100; i++) begin
      c_en = ens[i]; c_z = zs[i];
      d_en = ens[i]; d_z = zs[i];
      if (ens[i]) begin
        exp = model_bit(mc, zs[i]);
        mc = lfsr_step(mc);
      end else begin
        exp = c_val;
      end
      tick;
      outs[i] = c_val;
      checks++;
      if (c_val !== exp || d_val !== exp) begin
        errors++;
        $display("FAIL twin cycle %0d: got c=%b d=%b want %b", i, c_val, d_val, exp);
      end
    end
    c_en = 1'b0;
    d_rst = 1'b1; d_en = 1'b1; d_z = 7'b0_0111_11;
    tick;
    checks++;
    if (d_val !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_priority: got %b want 0", d_val);
    end
    d_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d_en = ens[i]; d_z = zs[i];
      tick;
      checks++;
      if (d_val !== outs[i]) begin
        errors++;
        $display("FAIL replay cycle %0d: got %b want %b", i, d_val, outs[i]);
      end
    end
    d_en = 1'b0;
    $display("back_to_back: 100 twin cycles, reset, 100 replay cycles");
  endtask

  initial begin
    test_reset;
    test_hold;
    test_statistics;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
